// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory round-robin arbiter.
// Optional stall counters are built when IMEM_ARB_PERF_EN is defined.
package imem_arb_pkg;

    // Width of each per-core stall counter.
    localparam int CNT_W   = 16;

    // Largest requester count the rr_pick helper function supports.
    localparam int MAX_REQ = 8;

    // Width of a requester index.
    // The result is clamped to 1 so a single-requester build still has a valid vector.
    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Reference round-robin pick for up to MAX_REQ requesters.
    // Returns the first set bit of valid, searching from ptr upward modulo n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [2:0]         ptr,
                                      input int                 n);
        pick_t      r;
        int         i;
        logic [2:0] ii;
        r = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                i  = (int'(ptr) + k) % n;
                ii = 3'(i);
                if (valid[ii]) begin
                    r.found = 1'b1;
                    r.idx   = ii;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// Combinational round-robin picker: rotate by ptr, priority-encode, un-rotate.
// Shared with the cluster NoC port arbiters.
module rr_pick_n #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx,
    output logic [N-1:0]  grant
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             off;
    int             w;

    // Search valid from ptr upward modulo N.
    // Returns the winner index, its one-hot grant and a found flag.
    always_comb begin
        dbl   = {valid, valid};
        rot   = dbl[ptr +: N];
        found = |rot;
        off   = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) off = j;
        end
        w = int'(ptr) + off;
        if (w >= N) w = w - N;
        idx   = PW'(w);
        grant = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/imem_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous-read instruction memory
// between N_REQ fetch ports. One grant per cycle; the response returns one cycle later.
// Define IMEM_ARB_PERF_EN to add the per-core saturating stall counters (stall_cnt).
module imem_rr_arbiter
    import imem_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*AW-1:0]        req_addr,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           resp_valid,
    output logic [DW-1:0]              resp_data,
    output logic                       resp_err,
    input  logic                       hold,
    output logic                       mem_en,
    output logic [$clog2(DEPTH)-1:0]   mem_addr,
    input  logic [DW-1:0]              mem_rdata
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [N_REQ*CNT_W-1:0]     stall_cnt
`endif
);

    localparam int              TAG_W   = tag_w(N_REQ);
    localparam int              MAW     = $clog2(DEPTH);
    localparam logic [AW-1:0]   DEPTH_A = AW'(DEPTH);

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;

    logic             found;
    logic [TAG_W-1:0] win_idx;
    logic [N_REQ-1:0] win_oh;
    logic [AW-1:0]    win_addr;
    logic             win_oor;
    logic             grant_en;

    rr_pick_n #(
        .N  (N_REQ),
        .PW (TAG_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .found (found),
        .idx   (win_idx),
        .grant (win_oh)
    );

    // Grant and memory request for the winner.
    // Suppressed while hold is high or while in reset.
    always_comb begin
        win_addr  = req_addr[int'(win_idx)*AW +: AW];
        win_oor   = (win_addr >= DEPTH_A);
        grant_en  = found & ~hold & rst_n;
        req_ready = grant_en ? win_oh : '0;
        mem_en    = grant_en & ~win_oor;
        mem_addr  = win_addr[MAW-1:0];
    end

    // Next-state logic for the pointer and the response stage.
    // The pointer moves past the winner only on a grant.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_en) begin
            if (int'(win_idx) == N_REQ - 1) rr_ptr_d = '0;
            else                            rr_ptr_d = win_idx + 1'b1;
        end
        vld_d = grant_en;
        tag_d = grant_en ? win_idx : tag_q;
        err_d = grant_en & win_oor;
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            tag_q    <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    // Response outputs.
    // Data is forced to zero when no response is valid or the address was out of range.
    always_comb begin
        resp_valid = vld_q ? (N_REQ'(1) << tag_q) : '0;
        resp_err   = vld_q & err_q;
        resp_data  = (vld_q & ~err_q) ? mem_rdata : '0;
    end

`ifdef IMEM_ARB_PERF_EN
    logic [CNT_W-1:0] stall_q [N_REQ];
    logic [CNT_W-1:0] stall_d [N_REQ];

    // Per-core saturating count of cycles spent requesting without a grant.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            stall_d[i] = stall_q[i];
            if (req_valid[i] && !req_ready[i] && (stall_q[i] != {CNT_W{1'b1}}))
                stall_d[i] = stall_q[i] + 1'b1;
            stall_cnt[i*CNT_W +: CNT_W] = stall_q[i];
        end
    end

    // Stall counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) stall_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) stall_q[i] <= stall_d[i];
        end
    end
`endif

endmodule

// File: doc/imem_rr_arbiter.md
Name: imem_rr_arbiter

Overview:
- Shares one synchronous-read instruction memory (single read port, DEPTH words) between N_REQ core fetch ports in the multicore cluster.
- Round-robin grant of at most one fetch per cycle; read data returns one cycle later, tagged to the granted core.
- Sits between the per-node fetch stages and a shared program memory, so identical programs on many nodes need only one memory image.

Parameters:
- N_REQ, 4, number of requesting cores (2..8).
- AW, 32, requester address width (word address).
- DW, 32, instruction width.
- DEPTH, 64, words in the shared memory; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  fetch request per core; held with its address until accepted.
- req_addr  in  N_REQ*AW  packed word addresses; core i at bits [i*AW +: AW].
- req_ready  out  N_REQ  one-hot grant, combinational, same cycle as acceptance.
- resp_valid  out  N_REQ  one-hot, one-cycle pulse one cycle after grant.
- resp_data  out  DW  instruction for the core flagged in resp_valid.
- resp_err  out  1  set together with resp_valid when the granted address was >= DEPTH.
- hold  in  1  freeze arbitration (debug/halt); no new grants while high.
- mem_en  out  1  memory read enable.
- mem_addr  out  $clog2(DEPTH)  memory word address.
- mem_rdata  in  DW  memory data, valid the cycle after mem_en.

Behaviour:
- Reset (async, rst_n=0): rr_ptr=0, resp_valid=0, resp_err=0, resp_data=0, pending tag cleared; req_ready=0 and mem_en=0 while in reset.
- Grant: each cycle with hold=0, the winner is the first i with req_valid[i]=1, searched from rr_ptr upward modulo N_REQ. req_ready[winner]=1, all other bits 0.
- Same cycle as the grant:
  - mem_en=1 and mem_addr=req_addr[winner] truncated to $clog2(DEPTH) bits.
  - If the full address is >= DEPTH, mem_en=0 and err_q is set.
- rr_ptr update: on a grant, rr_ptr <= (winner+1) mod N_REQ. With no grant, rr_ptr holds.
- Response register stage (tag_q, vld_q, err_q):
  - One cycle after the grant, resp_valid[tag_q]=1 for exactly one cycle.
  - resp_data=mem_rdata, or 0 when err_q=1; resp_err=err_q.
  - resp_data is 0 whenever resp_valid=0.
- Throughput and latency: one grant per cycle and back-to-back grants allowed. Latency is fixed at 1 cycle from grant to response.
- hold=1: req_ready=0 and mem_en=0. A response already in flight still completes on the next cycle. rr_ptr is frozen.
- A request must stay valid with a stable address until granted. Dropping req_valid before grant is legal; the request is simply not served.
- All req_valid=0: no grant, rr_ptr unchanged, mem_en=0.
- N_REQ=1: degenerates to a pass-through with a 1-cycle response.
- Reset mid-operation drops the in-flight response; no resp_valid is produced after rst_n rises until a new grant.
- Fairness: a continuously requesting core is granted within N_REQ cycles when hold=0.

Optional Feature:
- Macro IMEM_ARB_PERF_EN.
- Defined:
  - Adds output stall_cnt (N_REQ*16): per-core saturating 16-bit counter.
  - The counter increments each cycle with req_valid[i]=1 and req_ready[i]=0, and saturates at 16'hFFFF.
  - Cleared by reset only.
- Undefined: no counters and no stall_cnt port; behaviour otherwise identical.

Decomposition:
- Package imem_arb_pkg holds:
  - the TAG_W = $clog2(N_REQ) helper;
  - the counter width constant (16);
  - a function rr_pick(valid, ptr) returning the winner index and a found flag.
- One sub-module, rr_pick_n: combinational rotate / priority-encode / un-rotate, reused by the cluster's NoC port arbiters.

Test Plan:
- Single core: N_REQ=4, rst_n released, req_valid=4'b0010, addr=5, mem[5]=32'h00500293 -> req_ready=4'b0010 same cycle, mem_addr=5; next cycle resp_valid=4'b0010, resp_data=32'h00500293, resp_err=0.
- All four requesting continuously from rr_ptr=0 -> grants in order 0,1,2,3,0 on consecutive cycles; responses follow one cycle behind with matching data.
- Out of range: core 3 addr=64 -> req_ready[3]=1, mem_en=0; next cycle resp_valid=4'b1000, resp_data=0, resp_err=1.
- hold raised the cycle after granting core 0 (cores 0 and 2 requesting) -> core 0 response still delivered; no grants while hold=1; after release core 2 is granted first (rr_ptr=1).
- Reset asserted the cycle after a grant -> resp_valid stays 0 through and after reset; rr_ptr=0, so core 0 wins the first contested grant.
- With IMEM_ARB_PERF_EN: cores 0 and 1 request for 10 cycles -> stall_cnt[0] and stall_cnt[1] each = 5; a core starved for 70000 cycles (hold=1) reads 16'hFFFF.
